seq_div_16bit: RTL and testbench
================================

Name: seq_div_16bit

Overview:
Multi-cycle restoring divider, the inverse-direction companion to the team's saturating 16-bit add/sub datapath. It accepts a dividend/divisor pair on a start pulse and iterates one shift-subtract step per cycle. It returns quotient and remainder with a done pulse. It sits beside the ALU as a long-latency functional unit, and the same saturation policy applies: signed overflow clamps to 16'h7FFF.

Parameters:
WIDTH, 16, operand/result width; the counter is $clog2(WIDTH)+1 bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
signed_op  input  1  1 = two's-complement divide, 0 = unsigned
dividend  input  WIDTH  numerator, captured at accepted start
divisor  input  WIDTH  denominator, captured at accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  registered result, held until the next done
remainder  output  WIDTH  registered result, held until the next done
div_by_zero  output  1  registered flag, updated with done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, div_by_zero=0; quotient, remainder, internal regs, counter=0. Reset mid-operation aborts silently, with no done pulse.
- States are IDLE, CALC, FIX.
- IDLE with start=1 and divisor!=0:
  - Latch the magnitudes |dividend| and |divisor| (absolute value only when signed_op=1).
  - Latch the sign bits and signed_op; set partial remainder=0 and count=0.
  - Go to CALC.
- IDLE with start=1 and divisor==0: at the same edge, quotient=16'hFFFF, remainder=dividend, div_by_zero=1, done=1. State stays IDLE; busy never rises.
- CALC performs one step per cycle:
  - Shift {rem,quo} left by 1.
  - trial = rem - divisor_mag, computed at WIDTH+1 bits.
  - If trial is non-negative, rem=trial and quo[0]=1; otherwise quo[0]=0.
  - count++. After WIDTH steps (count==WIDTH), go to FIX.
- FIX applies signs and registers the outputs:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - If signed_op and dividend==16'h8000 and divisor==16'hFFFF: quotient=16'h7FFF (saturated), remainder=0.
  - done=1, div_by_zero=0, next state IDLE.
- Latency: start accepted at edge E0. done is high for the cycle following edge E17 (WIDTH+1 edges). busy is high from E0 to E17; busy and done are never both high.
- done is low in every cycle except the one pulse.
- Unsigned results truncate; signed results truncate toward zero. The invariant dividend == quotient*divisor + remainder holds for all non-saturated, non-zero-divisor cases.
- start while busy (CALC/FIX) is ignored, and operands are not re-sampled.
- start in the same cycle as done (state IDLE) is accepted normally, giving back-to-back operation.
- Outputs change only on done edges.

Decomposition:
- Shared package: state enum (IDLE, CALC, FIX), DIV_W=16, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000, DBZ_QUOT=16'hFFFF.
- Sub-module div_step: combinational, one shift-subtract iteration.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem, next quo.
  - Instantiated once by the FSM.

Test Plan:
- Unsigned 100/7 (signed_op=0) -> quotient=14 (16'h000E), remainder=2, div_by_zero=0; done exactly 17 cycles after start, busy high 17 cycles.
- Signed -100/7 -> quotient=16'hFFF2 (-14), remainder=16'hFFFE (-2). Signed 100/-7 -> quotient=16'hFFF2, remainder=16'h0002.
- Divide by zero, 16'h04D2/0 -> next cycle: done=1, div_by_zero=1, quotient=16'hFFFF, remainder=16'h04D2, busy stays 0.
- Signed overflow 16'h8000/16'hFFFF -> quotient=16'h7FFF, remainder=0. The same operands unsigned (32768/65535) -> quotient=0, remainder=16'h8000.
- Busy and back-to-back:
  - Start 50/5, then pulse start with 9/3 mid-CALC -> ignored; result 10 r0.
  - Start 9/3 in the done cycle -> result 3 r0, done 17 cycles later.
- Reset mid-op: assert rst_n=0 during CALC, asynchronously between edges -> all outputs 0 immediately, no done; a subsequent 65535/16'h0100 unsigned -> quotient=16'h00FF, remainder=16'h00FF.

Source files
------------

// File: rtl/seq_div_16bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_16bit_pkg
// Purpose  : Shared state encoding and result constants for the divider.
// Revision : 1.0 - initial release
// ============================================================================
package seq_div_16bit_pkg;

  localparam int          DIV_W    = 16;
  localparam logic [15:0] SAT_MAX  = 16'h7FFF;
  localparam logic [15:0] SAT_MIN  = 16'h8000;
  localparam logic [15:0] DBZ_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_div_16bit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_16bit_div_step
// Purpose  : One combinational restoring shift-subtract iteration.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_16bit_div_step
  import seq_div_16bit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  always_comb begin
    w_shift = {rem, quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, divisor_mag};
    // A set top bit in the shifted remainder always exceeds the divisor;
    // otherwise bit WIDTH of the difference is the borrow.
    w_fits  = w_shift[WIDTH] | ~w_trial[WIDTH];
    if (w_fits) begin
      rem_next = w_trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = w_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_div_16bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_16bit
// Purpose  : Multi-cycle restoring divider, signed/unsigned, saturating.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_16bit
  import seq_div_16bit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               c_cnt_w     = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
  localparam logic [WIDTH-1:0] c_sat_max   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_dbz_quot  = {WIDTH{1'b1}};

  div_state_t         r_state, w_state;
  logic [c_cnt_w-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0]   r_rem, w_rem;
  logic [WIDTH-1:0]   r_quo, w_quo;
  logic [WIDTH-1:0]   r_dmag, w_dmag;
  logic               r_neg_q, w_neg_q;
  logic               r_neg_r, w_neg_r;
  logic               r_signed, w_signed;
  logic [WIDTH-1:0]   r_quotient, w_quotient;
  logic [WIDTH-1:0]   r_remainder, w_remainder;
  logic               r_dbz, w_dbz;
  logic               r_done, w_done;

  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic               w_dvd_neg;
  logic               w_dvs_neg;

  seq_div_16bit_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem         (r_rem),
    .quo         (r_quo),
    .divisor_mag (r_dmag),
    .rem_next    (w_step_rem),
    .quo_next    (w_step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dmag      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_signed    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_rem       <= w_rem;
      r_quo       <= w_quo;
      r_dmag      <= w_dmag;
      r_neg_q     <= w_neg_q;
      r_neg_r     <= w_neg_r;
      r_signed    <= w_signed;
      r_quotient  <= w_quotient;
      r_remainder <= w_remainder;
      r_dbz       <= w_dbz;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_rem       = r_rem;
    w_quo       = r_quo;
    w_dmag      = r_dmag;
    w_neg_q     = r_neg_q;
    w_neg_r     = r_neg_r;
    w_signed    = r_signed;
    w_quotient  = r_quotient;
    w_remainder = r_remainder;
    w_dbz       = r_dbz;
    w_done      = 1'b0;
    w_dvd_neg   = signed_op & dividend[WIDTH-1];
    w_dvs_neg   = signed_op & divisor[WIDTH-1];

    case (r_state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            w_quotient  = c_dbz_quot;
            w_remainder = dividend;
            w_dbz       = 1'b1;
            w_done      = 1'b1;
          end else begin
            w_quo    = w_dvd_neg ? (~dividend + 1'b1) : dividend;
            w_dmag   = w_dvs_neg ? (~divisor + 1'b1) : divisor;
            w_rem    = '0;
            w_cnt    = '0;
            w_neg_q  = w_dvd_neg ^ w_dvs_neg;
            w_neg_r  = w_dvd_neg;
            w_signed = signed_op;
            w_state  = CALC;
          end
        end
      end

      CALC: begin
        w_rem = w_step_rem;
        w_quo = w_step_quo;
        w_cnt = r_cnt + c_one;
        if (r_cnt == c_last) begin
          w_state = FIX;
        end
      end

      FIX: begin
        w_quotient  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_remainder = r_neg_r ? (~r_rem + 1'b1) : r_rem;
        // A positive signed quotient with the MSB set only arises from MIN / -1.
        if (r_signed && !r_neg_q && r_quo[WIDTH-1]) begin
          w_quotient  = c_sat_max;
          w_remainder = '0;
        end
        w_dbz   = 1'b0;
        w_done  = 1'b1;
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_div_16bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div_16bit
// Purpose  : Scoreboard bench for seq_div_16bit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div_16bit;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  seq_div_16bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; SV '/' and '%' truncate toward zero.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sg, input int c);
    exp_t e;
    int   sa, sbv, qi, ri;
    e.cyc = c;
    e.dbz = 1'b0;
    e.lat = 17;
    if (b == 16'h0) begin
      e.q   = 16'hFFFF;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 0;
    end else if (!sg) begin
      e.q = a / b;
      e.r = a % b;
    end else begin
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      if (sa == -32768 && sbv == -1) begin
        e.q = 16'h7FFF;
        e.r = 16'h0000;
      end else begin
        qi  = sa / sbv;
        ri  = sa % sbv;
        e.q = qi[15:0];
        e.r = ri[15:0];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pending result (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(mon_e.q));
          check("remainder", 32'(remainder), 32'(mon_e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
          check("latency", 32'(cyc - mon_e.cyc), 32'(mon_e.lat));
          check("busy_with_done", 32'(busy), 32'(0));
          check("busy_cycles", 32'(busy_cnt), 32'(mon_e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called just after a rising edge; waits out any running operation.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sg);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 required 0 within 100 cycles");
    end
    dividend  = a;
    divisor   = b;
    signed_op = sg;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(a, b, sg, cyc));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    logic [15:0] a, b;
    logic        sg;
    int          sel;

    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 16'h0;
    divisor   = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_dbz", 32'(div_by_zero), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd100, 16'd7, 1'b0);
    run_op(16'hFF9C, 16'd7, 1'b1);
    run_op(16'd100, 16'hFFF9, 1'b1);
    run_op(16'h04D2, 16'h0000, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b1);
    run_op(16'h8000, 16'hFFFF, 1'b0);

    // Second request mid-calculation must be dropped.
    run_op(16'd50, 16'd5, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'hBEEF;
    run_op(16'd9, 16'd3, 1'b0);
    wait_idle();

    // Abort an operation with an asynchronous reset between clock edges.
    dividend  = 16'd1234;
    divisor   = 16'd7;
    signed_op = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_quotient", 32'(quotient), 32'(0));
    check("abort_remainder", 32'(remainder), 32'(0));
    check("abort_dbz", 32'(div_by_zero), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'hFFFF, 16'h0100, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sg  = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      b = 16'h0000;
      else if (sel == 1) b = 16'hFFFF;
      else if (sel == 2) b = 16'($urandom_range(1, 15));
      else               b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h8000;
      run_op(a, b, sg);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
